// File: rtl/dac_xy_sequencer.sv
// Point FIFO feeding a dual-channel DAC as atomic x/y pairs.
// One guard cycle after each strobe keeps strobes one per ready window.
module dac_xy_sequencer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pt_strobe,
    input  logic [11:0]   pt_x,
    input  logic [11:0]   pt_y,
    output logic          pt_ready,
    output logic [11:0]   dac_value,
    output logic          dac_axis,
    output logic          dac_strobe,
    input  logic          dac_ready,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    output logic [15:0]   pairs_sent
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_X_WAIT,
        S_X_GUARD,
        S_Y_WAIT,
        S_Y_GUARD
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [23:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [11:0]   r_x_hold;
    logic [11:0]   r_y_hold;
    logic [11:0]   r_value;
    logic          r_axis;
    logic          r_strobe;
    logic          r_overflow;
    logic [15:0]   r_pairs;

    logic          w_full;
    logic          w_nonempty;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_load_x;
    logic          w_load_y;
    logic          w_pair_done;
    logic [23:0]   w_head;

    assign w_full     = (r_count == FULL);
    assign w_nonempty = (r_count != '0);
    assign w_push     = pt_strobe && !w_full;
    assign w_drop     = pt_strobe && w_full;
    assign w_head     = r_mem[r_rd_ptr];

    assign pt_ready   = !w_full && !reset;
    assign dac_value  = r_value;
    assign dac_axis   = r_axis;
    assign dac_strobe = r_strobe;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign pairs_sent = r_pairs;

    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_load_x    = 1'b0;
        w_load_y    = 1'b0;
        w_pair_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_nonempty) begin
                    w_pop  = 1'b1;
                    w_next = S_X_WAIT;
                end
            end
            S_X_WAIT: begin
                if (dac_ready) begin
                    w_load_x = 1'b1;
                    w_next   = S_X_GUARD;
                end
            end
            // DAC ready is deliberately ignored while the strobe is high
            S_X_GUARD: begin
                w_next = S_Y_WAIT;
            end
            S_Y_WAIT: begin
                if (dac_ready) begin
                    w_load_y = 1'b1;
                    w_next   = S_Y_GUARD;
                end
            end
            S_Y_GUARD: begin
                w_pair_done = 1'b1;
                if (w_nonempty) begin
                    w_pop  = 1'b1;
                    w_next = S_X_WAIT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {pt_x, pt_y};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_x_hold   <= '0;
            r_y_hold   <= '0;
            r_value    <= '0;
            r_axis     <= 1'b0;
            r_strobe   <= 1'b0;
            r_overflow <= 1'b0;
            r_pairs    <= '0;
        end else begin
            r_state  <= w_next;
            r_strobe <= w_load_x || w_load_y;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_x_hold <= w_head[23:12];
                r_y_hold <= w_head[11:0];
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end

            if (w_load_x) begin
                r_value <= r_x_hold;
                r_axis  <= 1'b0;
            end else if (w_load_y) begin
                r_value <= r_y_hold;
                r_axis  <= 1'b1;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pair_done) begin
                r_pairs <= r_pairs + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dac_xy_sequencer.sv
// Bench for dac_xy_sequencer: timing vectors, corner sequences
// and a randomized stream checked against an ordered point queue.
module tb_dac_xy_sequencer;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pt_strobe = 1'b0;
    logic [11:0]   pt_x = '0;
    logic [11:0]   pt_y = '0;
    logic          pt_ready;
    logic [11:0]   dac_value;
    logic          dac_axis;
    logic          dac_strobe;
    logic          dac_ready = 1'b0;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [15:0]   pairs_sent;

    always #5 clk = ~clk;

    dac_xy_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pt_strobe  (pt_strobe),
        .pt_x       (pt_x),
        .pt_y       (pt_y),
        .pt_ready   (pt_ready),
        .dac_value  (dac_value),
        .dac_axis   (dac_axis),
        .dac_strobe (dac_strobe),
        .dac_ready  (dac_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .pairs_sent (pairs_sent)
    );

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        int          dx;
        int          dy;
        int          xs;
        int          ys;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int obs_v[$];
    int obs_a[$];
    int obs_c[$];
    int exp_v[$];
    bit last_strobe = 1'b0;
    int dac_mode = 0;
    int stall = 0;
    int n_x = 0;
    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (dac_strobe) begin
            chk("strobe_window", int'(dac_ready && !last_strobe), 1);
            obs_v.push_back(int'(dac_value));
            obs_a.push_back(int'(dac_axis));
            obs_c.push_back(cyc);
            if (!dac_axis) n_x++;
        end
        last_strobe = dac_strobe;
        if (dac_mode == 1) begin
            if (dac_strobe) stall = 30;
            else if (stall > 0) stall--;
            dac_ready = (stall == 0);
        end else if (dac_mode == 2) begin
            if (dac_strobe) stall = int'($urandom_range(1, 6));
            else if (stall > 0) stall--;
            dac_ready = (stall == 0) && ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic clear_obs();
        obs_v.delete();
        obs_a.delete();
        obs_c.delete();
        exp_v.delete();
        n_x = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pt_strobe = 1'b0;
        #1;
        chk("pt_ready_in_reset", int'(pt_ready), 0);
        step();
        step();
        reset = 1'b0;
        clear_obs();
    endtask

    task automatic push(input int x, input int y);
        pt_x = 12'(x);
        pt_y = 12'(y);
        pt_strobe = 1'b1;
        step();
        pt_strobe = 1'b0;
    endtask

    task automatic check_seq(input string name, input int n);
        chk({name, "_count"}, obs_v.size(), n);
        for (int i = 0; i < n; i++) begin
            chk({name, "_value"}, qget(obs_v, i), qget(exp_v, i));
            chk({name, "_axis"}, qget(obs_a, i), i % 2);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xs_seen;
        int n_pushed;
        bit found;
        bit armed;
        bit chk_next;

        vecs[0] = '{12'd15,   12'd10,   0,  0,  3,  5};
        vecs[1] = '{12'hFFF,  12'h000,  5,  1,  6,  8};
        vecs[2] = '{12'h000,  12'hFFF,  2,  4,  3,  8};
        vecs[3] = '{12'hABC,  12'h123, 10, 10, 11, 22};
        vecs[4] = '{12'd1,    12'd2,    3,  2,  4,  7};

        do_reset();
        dac_ready = 1'b1;
        for (int k = 0; k < 20; k++) step();
        chk("rst_no_strobe", obs_v.size(), 0);
        chk("rst_value", int'(dac_value), 0);
        chk("rst_axis", int'(dac_axis), 0);
        chk("rst_strobe", int'(dac_strobe), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_pairs", int'(pairs_sent), 0);
        chk("rst_pt_ready", int'(pt_ready), 1);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            dac_mode = 0;
            dac_ready = 1'b0;
            step();
            cyc = 0;
            pt_x = vecs[i].x;
            pt_y = vecs[i].y;
            pt_strobe = 1'b1;
            dac_ready = (vecs[i].dx == 0);
            xs_seen = -1;
            for (int k = 0; k < 60; k++) begin
                step();
                pt_strobe = 1'b0;
                if (xs_seen < 0 && obs_c.size() > 0) xs_seen = obs_c[0];
                dac_ready = (xs_seen < 0) ? (cyc >= vecs[i].dx)
                                          : (cyc >= xs_seen + vecs[i].dy);
            end
            chk("vec_strobes", obs_v.size(), 2);
            chk("vec_x_cycle", qget(obs_c, 0), vecs[i].xs);
            chk("vec_x_value", qget(obs_v, 0), int'(vecs[i].x));
            chk("vec_x_axis", qget(obs_a, 0), 0);
            chk("vec_y_cycle", qget(obs_c, 1), vecs[i].ys);
            chk("vec_y_value", qget(obs_v, 1), int'(vecs[i].y));
            chk("vec_y_axis", qget(obs_a, 1), 1);
            chk("vec_pairs", int'(pairs_sent), 1);
            chk("vec_count", int'(fifo_count), 0);
        end

        do_reset();
        dac_mode = 1;
        stall = 0;
        dac_ready = 1'b1;
        push(1, 2);
        push(3, 4);
        push(5, 6);
        for (int k = 0; k < 400 && obs_v.size() < 6; k++) step();
        for (int k = 0; k < 3; k++) step();
        for (int i = 1; i <= 6; i++) exp_v.push_back(i);
        check_seq("stall", 6);
        chk("stall_pairs", int'(pairs_sent), 3);

        do_reset();
        dac_mode = 0;
        dac_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(16'h100 + i, 16'h200 + i);
        chk("ovf_count", int'(fifo_count), DEPTH);
        chk("ovf_pt_ready", int'(pt_ready), 0);
        chk("ovf_flag", int'(overflow), 1);
        for (int i = 0; i < 5; i++) begin
            exp_v.push_back(16'h100 + i);
            exp_v.push_back(16'h200 + i);
        end
        dac_ready = 1'b1;
        armed = 1'b0;
        chk_next = 1'b0;
        for (int k = 0; k < 200 && obs_v.size() < 10; k++) begin
            step();
            pt_strobe = 1'b0;
            if (chk_next) begin
                chk("drop_on_pop_count", int'(fifo_count), DEPTH - 1);
                chk("drop_on_pop_ovf", int'(overflow), 1);
                chk_next = 1'b0;
            end
            if (!armed && dac_strobe && dac_axis) begin
                pt_x = 12'hEEE;
                pt_y = 12'hEEE;
                pt_strobe = 1'b1;
                armed = 1'b1;
                chk_next = 1'b1;
            end
        end
        for (int k = 0; k < 3; k++) step();
        check_seq("ovf", 10);
        chk("ovf_pairs", int'(pairs_sent), 5);
        chk("ovf_drain", int'(fifo_count), 0);

        do_reset();
        dac_mode = 0;
        dac_ready = 1'b0;
        push(100, 200);
        push(9, 19);
        push(11, 21);
        dac_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            step();
            if (dac_strobe && !dac_axis && dac_value == 12'd100) found = 1'b1;
        end
        chk("mid_x100_seen", int'(found), 1);
        reset = 1'b1;
        #1;
        chk("mid_pt_ready", int'(pt_ready), 0);
        step();
        chk("mid_strobe", int'(dac_strobe), 0);
        chk("mid_count", int'(fifo_count), 0);
        chk("mid_pairs", int'(pairs_sent), 0);
        step();
        reset = 1'b0;
        clear_obs();
        for (int k = 0; k < 20; k++) step();
        chk("mid_no_strobe", obs_v.size(), 0);
        push(7, 8);
        for (int k = 0; k < 10; k++) step();
        exp_v.push_back(7);
        exp_v.push_back(8);
        check_seq("mid_new", 2);
        chk("mid_new_pairs", int'(pairs_sent), 1);

        do_reset();
        dac_mode = 2;
        stall = 0;
        n_pushed = 0;
        for (int k = 0; k < 6000; k++) begin
            if ((n_pushed - n_x) < DEPTH && $urandom_range(0, 2) == 0) begin
                pt_x = 12'($urandom);
                pt_y = 12'($urandom);
                pt_strobe = 1'b1;
                exp_v.push_back(int'(pt_x));
                exp_v.push_back(int'(pt_y));
                n_pushed++;
                #1;
                chk("rnd_pt_ready", int'(pt_ready), 1);
            end else begin
                pt_strobe = 1'b0;
            end
            step();
        end
        pt_strobe = 1'b0;
        for (int k = 0; k < 3000 && obs_v.size() < 2 * n_pushed; k++) step();
        for (int k = 0; k < 3; k++) step();
        check_seq("rnd", 2 * n_pushed);
        chk("rnd_pairs", int'(pairs_sent), n_pushed % 65536);
        chk("rnd_count", int'(fifo_count), 0);
        chk("rnd_overflow", int'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
